// File: rtl/vivaldi_seq_if.sv
// vivaldi_seq control/config bundle: table programming, run control and oscillator drive.
// VIVALDI_SEQ_LOOP_EN adds the loop_i request line.
interface vivaldi_seq_if #(
    parameter int NUM_STEPS = 8,
    parameter int DUR_W     = 24,
    parameter int AW        = $clog2(NUM_STEPS)
);
    logic             cfg_we_i;
    logic [AW-1:0]    cfg_addr_i;
    logic [1:0]       cfg_wave_i;
    logic [6:0]       cfg_gain_i;
    logic [DUR_W-1:0] cfg_dur_i;
    logic [AW:0]      num_steps_i;
    logic             start_i;
    logic             stop_i;
    logic             sample_tick_i;
`ifdef VIVALDI_SEQ_LOOP_EN
    logic             loop_i;
`endif
    logic [1:0]       wave_sel_o;
    logic [6:0]       gain_o;
    logic             osc_en_o;
    logic [AW-1:0]    step_o;
    logic             busy_o;
    logic             done_o;

    modport master (
        output cfg_we_i, cfg_addr_i, cfg_wave_i, cfg_gain_i, cfg_dur_i,
        output num_steps_i, start_i, stop_i, sample_tick_i,
`ifdef VIVALDI_SEQ_LOOP_EN
        output loop_i,
`endif
        input  wave_sel_o, gain_o, osc_en_o, step_o, busy_o, done_o
    );

    modport slave (
        input  cfg_we_i, cfg_addr_i, cfg_wave_i, cfg_gain_i, cfg_dur_i,
        input  num_steps_i, start_i, stop_i, sample_tick_i,
`ifdef VIVALDI_SEQ_LOOP_EN
        input  loop_i,
`endif
        output wave_sel_o, gain_o, osc_en_o, step_o, busy_o, done_o
    );
endinterface

// File: rtl/vivaldi_seq.sv
// Step sequencer driving vivaldi oscillator wave/gain/enable from a small program table.
// Define VIVALDI_SEQ_LOOP_EN to allow the program to repeat while loop_i is high.
module vivaldi_seq #(
    parameter int NUM_STEPS = 8,
    parameter int DUR_W     = 24,
    parameter int AW        = $clog2(NUM_STEPS)
) (
    input logic         clk_i,
    input logic         rst_ni,
    vivaldi_seq_if.slave io
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_PLAY
    } state_e;

    localparam logic [AW:0]      MAX_LEN  = (AW+1)'(NUM_STEPS);
    localparam logic [AW:0]      LEN_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0]    STEP_ONE = AW'(1);
    localparam logic [DUR_W-1:0] CNT_ONE  = DUR_W'(1);
    localparam logic [6:0]       GAIN_MAX = 7'd100;

    state_e state_q, state_d;

    logic [1:0]       tbl_wave [NUM_STEPS];
    logic [6:0]       tbl_gain [NUM_STEPS];
    logic [DUR_W-1:0] tbl_dur  [NUM_STEPS];

    logic [AW-1:0]    step_q, step_d;
    logic [AW:0]      len_q, len_d;
    logic [DUR_W-1:0] cnt_q, cnt_d;
    logic [1:0]       wave_q, wave_d;
    logic [6:0]       gain_q, gain_d;
    logic             en_q, en_d;
    logic             done_q, done_d;
    logic             busy_q;

    logic [AW:0]      len_in;
    logic [6:0]       gain_wr;
    logic             last_step;
    logic             step_end;
    logic             loop_en;
    logic [1:0]       rd_wave;
    logic [6:0]       rd_gain;
    logic [DUR_W-1:0] rd_dur;

`ifdef VIVALDI_SEQ_LOOP_EN
    assign loop_en = io.loop_i;
`else
    assign loop_en = 1'b0;
`endif

    assign len_in    = (io.num_steps_i > MAX_LEN) ? MAX_LEN : io.num_steps_i;
    assign gain_wr   = (io.cfg_gain_i > GAIN_MAX) ? GAIN_MAX : io.cfg_gain_i;
    assign last_step = (({1'b0, step_q}) + LEN_ONE) == len_q;
    assign rd_wave   = tbl_wave[step_q];
    assign rd_gain   = tbl_gain[step_q];
    assign rd_dur    = tbl_dur[step_q];

    // Table is frozen for the whole run so a running program is never disturbed.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NUM_STEPS; i++) begin
                tbl_wave[i] <= '0;
                tbl_gain[i] <= '0;
                tbl_dur[i]  <= '0;
            end
        end else if (io.cfg_we_i && state_q == S_IDLE) begin
            tbl_wave[io.cfg_addr_i] <= io.cfg_wave_i;
            tbl_gain[io.cfg_addr_i] <= gain_wr;
            tbl_dur[io.cfg_addr_i]  <= io.cfg_dur_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            step_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            wave_q  <= '0;
            gain_q  <= '0;
            en_q    <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            wave_q  <= wave_d;
            gain_q  <= gain_d;
            en_q    <= en_d;
            done_q  <= done_d;
            busy_q  <= (state_d != S_IDLE);
        end
    end

    always_comb begin
        state_d  = state_q;
        step_d   = step_q;
        len_d    = len_q;
        cnt_d    = cnt_q;
        wave_d   = wave_q;
        gain_d   = gain_q;
        en_d     = en_q;
        done_d   = 1'b0;
        step_end = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (io.start_i) begin
                    if (io.num_steps_i == '0) begin
                        done_d = 1'b1;
                    end else begin
                        len_d   = len_in;
                        step_d  = '0;
                        state_d = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                // A zero-length step leaves the outputs untouched.
                if (rd_dur == '0) begin
                    step_end = 1'b1;
                end else begin
                    wave_d  = rd_wave;
                    gain_d  = rd_gain;
                    en_d    = 1'b1;
                    cnt_d   = rd_dur;
                    state_d = S_PLAY;
                end
            end
            S_PLAY: begin
                if (io.sample_tick_i) begin
                    cnt_d = cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        step_end = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (step_end) begin
            if (!last_step) begin
                step_d  = step_q + STEP_ONE;
                state_d = S_LOAD;
            end else if (loop_en) begin
                step_d  = '0;
                state_d = S_LOAD;
            end else begin
                state_d = S_IDLE;
                en_d    = 1'b0;
                gain_d  = '0;
                done_d  = 1'b1;
            end
        end

        // Abort wins over start, step end and completion alike.
        if (io.stop_i) begin
            state_d = S_IDLE;
            step_d  = step_q;
            len_d   = len_q;
            en_d    = 1'b0;
            gain_d  = '0;
            done_d  = 1'b0;
        end
    end

    assign io.wave_sel_o = wave_q;
    assign io.gain_o     = gain_q;
    assign io.osc_en_o   = en_q;
    assign io.step_o     = step_q;
    assign io.busy_o     = busy_q;
    assign io.done_o     = done_q;

endmodule

// File: tb/tb_vivaldi_seq.sv
// Self-checking bench for vivaldi_seq: spec-level model compared every cycle
// plus directed scenarios with hand-computed expectations.
module tb_vivaldi_seq;
    localparam int NS = 8;
    localparam int DW = 24;
    localparam int AW = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    vivaldi_seq_if #(.NUM_STEPS(NS), .DUR_W(DW)) bus ();
    vivaldi_seq #(.NUM_STEPS(NS), .DUR_W(DW)) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .io    (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Spec-level model: a program is a list of (wave, gain, ticks) played in order.
    int  t_wave [NS];
    int  t_gain [NS];
    int  t_dur  [NS];
    int  m_wave = 0, m_gain = 0, m_en = 0, m_step = 0, m_busy = 0, m_done = 0;
    int  m_len = 0, m_left = 0;
    bit  m_loading = 0;

    task automatic model_reset();
        for (int i = 0; i < NS; i++) begin
            t_wave[i] = 0; t_gain[i] = 0; t_dur[i] = 0;
        end
        m_wave = 0; m_gain = 0; m_en = 0; m_step = 0;
        m_busy = 0; m_done = 0; m_len = 0; m_left = 0; m_loading = 0;
    endtask

    task automatic end_step(input bit lp);
        if (m_step < m_len - 1) begin
            m_step++; m_loading = 1;
        end else if (lp) begin
            m_step = 0; m_loading = 1;
        end else begin
            m_busy = 0; m_en = 0; m_gain = 0; m_done = 1;
        end
    endtask

    task automatic model_step();
        bit was_idle = (m_busy == 0);
        bit lp = 0;
        int n;
`ifdef VIVALDI_SEQ_LOOP_EN
        lp = bus.loop_i;
`endif
        m_done = 0;
        if (bus.stop_i) begin
            m_busy = 0; m_en = 0; m_gain = 0;
        end else if (m_busy == 0) begin
            if (bus.start_i) begin
                n = int'(bus.num_steps_i);
                if (n == 0) m_done = 1;
                else begin
                    m_busy = 1; m_loading = 1; m_step = 0;
                    m_len = (n > NS) ? NS : n;
                end
            end
        end else if (m_loading) begin
            if (t_dur[m_step] == 0) end_step(lp);
            else begin
                m_wave = t_wave[m_step]; m_gain = t_gain[m_step];
                m_en = 1; m_left = t_dur[m_step]; m_loading = 0;
            end
        end else if (bus.sample_tick_i) begin
            m_left--;
            if (m_left == 0) end_step(lp);
        end
        if (was_idle && bus.cfg_we_i) begin
            t_wave[bus.cfg_addr_i] = int'(bus.cfg_wave_i);
            t_gain[bus.cfg_addr_i] = (bus.cfg_gain_i > 100) ? 100 : int'(bus.cfg_gain_i);
            t_dur[bus.cfg_addr_i]  = int'(bus.cfg_dur_i);
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    int wq[$];
    int sq[$];
    int dn = 0;

    initial begin
        logic [13:0] exp_v;
        logic [13:0] act_v;
        forever begin
            @(negedge clk);
            exp_v = {2'(m_wave), 7'(m_gain), 1'(m_en), 3'(m_step), 1'(m_busy), 1'(m_done)};
            act_v = {bus.wave_sel_o, bus.gain_o, bus.osc_en_o, bus.step_o, bus.busy_o, bus.done_o};
            check("model_outputs", 64'(act_v), 64'(exp_v));
            if (bus.osc_en_o && (wq.size() == 0 || wq[$] != int'(bus.wave_sel_o)))
                wq.push_back(int'(bus.wave_sel_o));
            if (bus.busy_o && (sq.size() == 0 || sq[$] != int'(bus.step_o)))
                sq.push_back(int'(bus.step_o));
            if (bus.done_o) dn++;
        end
    end

    bit tick_en = 0;
    initial begin
        int c = 0;
        bus.sample_tick_i = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (tick_en) begin
                c++;
                bus.sample_tick_i = (c % 4 == 0);
            end else begin
                c = 0;
                bus.sample_tick_i = 1'b0;
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic wr(input int a, input int w, input int g, input int d);
        bus.cfg_we_i   = 1'b1;
        bus.cfg_addr_i = AW'(a);
        bus.cfg_wave_i = 2'(w);
        bus.cfg_gain_i = 7'(g);
        bus.cfg_dur_i  = DW'(d);
        cyc(1);
        bus.cfg_we_i   = 1'b0;
    endtask

    task automatic go(input int n);
        bus.num_steps_i = (AW+1)'(n);
        bus.start_i = 1'b1;
        cyc(1);
        bus.start_i = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string nm);
        int k = 0;
        while (!bus.done_o && k < budget) begin cyc(1); k++; end
        check(nm, 64'(bus.done_o), 64'd1);
    endtask

    task automatic wait_step1(input int budget);
        int k = 0;
        while (!(bus.step_o == 3'd1 && bus.osc_en_o) && k < budget) begin cyc(1); k++; end
        check("reach_step1", 64'(bus.step_o), 64'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        bus.cfg_we_i = 0; bus.cfg_addr_i = 0; bus.cfg_wave_i = 0;
        bus.cfg_gain_i = 0; bus.cfg_dur_i = 0; bus.num_steps_i = 0;
        bus.start_i = 0; bus.stop_i = 0;
`ifdef VIVALDI_SEQ_LOOP_EN
        bus.loop_i = 0;
`endif
        cyc(2);
        rst_n = 1'b1;
        cyc(1);
        check("rst_outputs", {bus.wave_sel_o, bus.gain_o, bus.osc_en_o, bus.step_o,
                              bus.busy_o, bus.done_o}, 64'd0);

        // Four steps, one per waveform, 3 ticks each.
        for (int i = 0; i < 4; i++) wr(i, i, 50, 3);
        wq.delete(); d0 = dn;
        go(4);
        check("lat_busy_n1", 64'(bus.busy_o), 64'd1);
        check("lat_en_n1", 64'(bus.osc_en_o), 64'd0);
        cyc(1);
        check("lat_en_n2", 64'(bus.osc_en_o), 64'd1);
        check("lat_gain_n2", 64'(bus.gain_o), 64'd50);
        tick_en = 1;
        wait_done(200, "prog4_done");
        tick_en = 0;
        cyc(1);
        check("prog4_waves", {32'(wq.size()), 8'(wq[0]), 8'(wq[1]), 8'(wq[2]), 8'(wq[3])},
              {32'd4, 8'd0, 8'd1, 8'd2, 8'd3});
        check("prog4_done_cnt", 64'(dn - d0), 64'd1);
        check("prog4_gain_after", 64'(bus.gain_o), 64'd0);
        check("prog4_step_hold", 64'(bus.step_o), 64'd3);

        // Gain clamp.
        wr(0, 1, 120, 2);
        go(1);
        cyc(1);
        check("gain_clamp", 64'(bus.gain_o), 64'd100);
        tick_en = 1;
        wait_done(100, "clamp_done");
        tick_en = 0;
        cyc(2);

        // Abort with simultaneous start during step 1.
        d0 = dn;
        go(4);
        tick_en = 1;
        wait_step1(100);
        bus.stop_i = 1'b1; bus.start_i = 1'b1; bus.num_steps_i = 4'd4;
        cyc(1);
        bus.stop_i = 1'b0; bus.start_i = 1'b0;
        tick_en = 0;
        check("stop_busy", 64'(bus.busy_o), 64'd0);
        check("stop_en_gain", {bus.osc_en_o, bus.gain_o}, 64'd0);
        cyc(2);
        check("stop_no_done", 64'(dn - d0), 64'd0);
        check("stop_stays_idle", 64'(bus.busy_o), 64'd0);

        // Empty program.
        go(0);
        check("empty_done", 64'(bus.done_o), 64'd1);
        check("empty_en", {bus.osc_en_o, bus.busy_o}, 64'd0);
        cyc(1);
        check("empty_done_pulse", 64'(bus.done_o), 64'd0);

        // Zero-duration step in the middle is skipped.
        wr(0, 1, 40, 2); wr(1, 2, 40, 0); wr(2, 3, 40, 2);
        wq.delete(); d0 = dn;
        go(3);
        tick_en = 1;
        wait_done(100, "skip_done");
        tick_en = 0;
        cyc(1);
        check("skip_waves", {32'(wq.size()), 16'(wq[0]), 16'(wq[1])}, {32'd2, 16'd1, 16'd3});
        check("skip_done_cnt", 64'(dn - d0), 64'd1);

        // Writes during play are dropped.
        wr(0, 2, 50, 5);
        go(1);
        cyc(1);
        wr(0, 1, 10, 1);
        check("wr_busy_play", {bus.wave_sel_o, bus.gain_o}, {2'd2, 7'd50});
        tick_en = 1;
        wait_done(100, "wr_busy_done1");
        tick_en = 0;
        cyc(1);
        go(1);
        cyc(1);
        check("wr_busy_readback", {bus.wave_sel_o, bus.gain_o}, {2'd2, 7'd50});
        tick_en = 1;
        wait_done(100, "wr_busy_done2");
        tick_en = 0;
        cyc(1);

`ifdef VIVALDI_SEQ_LOOP_EN
        // Looping two-step program, then one-shot after loop_i drops.
        wr(0, 0, 30, 1); wr(1, 1, 30, 1);
        bus.loop_i = 1'b1;
        sq.delete(); d0 = dn;
        go(2);
        tick_en = 1;
        cyc(40);
        check("loop_steps", {32'(sq.size() >= 4), 8'(sq[0]), 8'(sq[1]), 8'(sq[2]), 8'(sq[3])},
              {32'd1, 8'd0, 8'd1, 8'd0, 8'd1});
        check("loop_no_done", 64'(dn - d0), 64'd0);
        bus.loop_i = 1'b0;
        wait_done(100, "loop_exit_done");
        tick_en = 0;
        cyc(1);
        check("loop_done_cnt", 64'(dn - d0), 64'd1);
`endif

        // Reset mid-program clears outputs and table.
        wr(0, 2, 50, 5);
        go(1);
        cyc(2);
        rst_n = 1'b0;
        #1;
        check("rst_mid_outputs", {bus.wave_sel_o, bus.gain_o, bus.osc_en_o, bus.step_o,
                                  bus.busy_o, bus.done_o}, 64'd0);
        cyc(1);
        rst_n = 1'b1;
        cyc(1);
        go(1);
        check("rst_tbl_busy", 64'(bus.busy_o), 64'd1);
        cyc(1);
        check("rst_tbl_skip_done", {bus.done_o, bus.osc_en_o}, {1'b1, 1'b0});
        cyc(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
